// File: rtl/rr_requester.sv
// rr_requester: requester-side agent for a 4-channel round-robin arbiter.
// Each channel queues transfer requests pushed by its client. It raises
// req_i while a burst is in flight and counts granted beats. When a burst
// completes it pulses done_i and then drops req_i for one GAP cycle, so the
// arbiter can rotate to another channel.
//
// Ports:
//   clk                 system clock, rising edge
//   rst                 asynchronous reset, active low
//   push[3:0]           one-cycle pulse per channel: enqueue one transfer
//   gnt3..gnt0          grants from the arbiter
//   req3..req0          registered requests to the arbiter
//   done[3:0]           one-cycle pulse when a channel's burst completes
//   full[3:0]           channel's pending counter is at its maximum
//   err                 sticky protocol error (idle grant, multi-grant,
//                       push overflow)
module rr_requester #(
  parameter int BURST_LEN = 2,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] push,
  input  logic       gnt3,
  input  logic       gnt2,
  input  logic       gnt1,
  input  logic       gnt0,
  output logic       req3,
  output logic       req2,
  output logic       req1,
  output logic       req0,
  output logic [3:0] done,
  output logic [3:0] full,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [3:0]       BEAT_LAST = 4'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] PEND_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PEND_ONE  = CNT_W'(1);

  logic [3:0] gnt;
  logic [3:0] req_v;
  logic [3:0] done_v;
  logic [3:0] ovf_v;
  logic [3:0] idle_gnt_v;
  logic       multi_gnt;

  assign gnt = {gnt3, gnt2, gnt1, gnt0};

  // Clearing the lowest set bit leaves something only if two or more bits are set.
  assign multi_gnt = (gnt & (gnt - 4'd1)) != 4'd0;

  for (genvar i = 0; i < 4; i++) begin : g_ch
    state_t           state, state_nxt;
    logic [CNT_W-1:0] pend, pend_nxt;
    logic [3:0]       beat, beat_nxt;
    logic             last;
    logic             ovf;
    logic             req_r;
    logic             done_r;

    always_comb begin
      state_nxt = state;
      pend_nxt  = pend;
      beat_nxt  = beat;
      last      = 1'b0;
      ovf       = 1'b0;

      // A beat is counted only in REQ. Grants seen in GAP are ignored, to
      // tolerate one cycle of grant lag from the arbiter.
      if (state == S_REQ && gnt[i]) begin
        if (beat == BEAT_LAST) begin
          last     = 1'b1;
          beat_nxt = 4'd0;
        end else begin
          beat_nxt = beat + 4'd1;
        end
      end

      // A push and a completion on the same edge cancel out. A push while the
      // counter is full is dropped and flagged.
      if (push[i] && !last) begin
        if (pend == PEND_MAX) ovf = 1'b1;
        else                  pend_nxt = pend + PEND_ONE;
      end else if (!push[i] && last) begin
        pend_nxt = pend - PEND_ONE;
      end

      // Transitions look at the post-update pending count.
      case (state)
        S_IDLE:  if (pend_nxt != '0) state_nxt = S_REQ;
        S_REQ:   if (last) state_nxt = S_GAP;
        S_GAP:   state_nxt = (pend_nxt != '0) ? S_REQ : S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state  <= S_IDLE;
        pend   <= '0;
        beat   <= 4'd0;
        req_r  <= 1'b0;
        done_r <= 1'b0;
      end else begin
        state  <= state_nxt;
        pend   <= pend_nxt;
        beat   <= beat_nxt;
        // req is taken from the next state so it is high exactly while in REQ.
        req_r  <= (state_nxt == S_REQ);
        done_r <= last;
      end
    end

    assign req_v[i]      = req_r;
    assign done_v[i]     = done_r;
    assign full[i]       = (pend == PEND_MAX);
    assign ovf_v[i]      = ovf;
    assign idle_gnt_v[i] = (state == S_IDLE) && gnt[i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if ((|ovf_v) || (|idle_gnt_v) || multi_gnt) begin
      err <= 1'b1;
    end
  end

  assign {req3, req2, req1, req0} = req_v;
  assign done = done_v;

endmodule

// File: tb/tb_rr_requester.sv
module tb_rr_requester;

  localparam int BURST_LEN = 2;
  localparam int CNT_W     = 4;

  logic       clk;
  logic       rst;
  logic [3:0] push;
  logic [3:0] gnt;
  logic       req3, req2, req1, req0;
  logic [3:0] done;
  logic [3:0] full;
  logic       err;

  rr_requester #(.BURST_LEN(BURST_LEN), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .gnt3 (gnt[3]),
    .gnt2 (gnt[2]),
    .gnt1 (gnt[1]),
    .gnt0 (gnt[0]),
    .req3 (req3),
    .req2 (req2),
    .req1 (req1),
    .req0 (req0),
    .done (done),
    .full (full),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] full;
    logic       err;
    string      name;
  } exp_t;

  typedef struct {
    bit         rst_before;
    logic [3:0] push;
    logic [3:0] gnt;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] full;
    logic       err;
    string      name;
  } vec_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic compare(input exp_t e);
    logic [3:0] r;
    r = {req3, req2, req1, req0};
    checks++;
    if (r !== e.req || done !== e.done || full !== e.full || err !== e.err) begin
      errors++;
      $display("FAIL %s: got req=%b done=%b full=%b err=%b, want req=%b done=%b full=%b err=%b",
               e.name, r, done, full, err, e.req, e.done, e.full, e.err);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, and check after the edge.
  task automatic step(input logic [3:0] p, input logic [3:0] g, input logic [3:0] r,
                      input logic [3:0] d, input logic [3:0] f, input logic e,
                      input string name);
    exp_t x;
    push = p;
    gnt  = g;
    x = '{req: r, done: d, full: f, err: e, name: name};
    sb.push_back(x);
    @(posedge clk);
    #1;
    push = 4'd0;
    gnt  = 4'd0;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      compare(sb.pop_front());
    end
  endtask

  // Leaves the bench 1 time unit after a rising edge, with reset released.
  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic void add(input bit rb, input logic [3:0] p, input logic [3:0] g,
                              input logic [3:0] r, input logic [3:0] d, input logic [3:0] f,
                              input logic e, input string name);
    vec_t v;
    v = '{rst_before: rb, push: p, gnt: g, req: r, done: d, full: f, err: e, name: name};
    tbl.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    exp_t z;
    rst  = 1'b1;
    push = 4'd0;
    gnt  = 4'd0;
    #3 rst = 1'b0;
    #1;
    z = '{req: 4'd0, done: 4'd0, full: 4'd0, err: 1'b0, name: "reset_state"};
    compare(z);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Single transfer on channel 0.
    add(0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 0, "single_push");
    add(0, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0, "single_beat1");
    add(0, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 0, "single_done");
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, "single_idle");
    // Channels 1 and 2 sharing with alternating grants.
    add(0, 4'b0110, 4'b0000, 4'b0110, 4'b0000, 4'b0000, 0, "rr_push");
    add(0, 4'b0000, 4'b0010, 4'b0110, 4'b0000, 4'b0000, 0, "rr_g1a");
    add(0, 4'b0000, 4'b0100, 4'b0110, 4'b0000, 4'b0000, 0, "rr_g2a");
    add(0, 4'b0000, 4'b0010, 4'b0100, 4'b0010, 4'b0000, 0, "rr_done1");
    add(0, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 0, "rr_done2");
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, "rr_idle");
    // Three queued transfers on channel 3 with a continuous grant; grants in GAP are ignored.
    add(0, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 0, "b2b_push1");
    add(0, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 0, "b2b_push2");
    add(0, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 0, "b2b_done1");
    add(0, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 0, "b2b_gap1");
    add(0, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 0, "b2b_beat");
    add(0, 4'b0000, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 0, "b2b_done2");
    add(0, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 0, "b2b_gap2");
    add(0, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 0, "b2b_beat3");
    add(0, 4'b0000, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 0, "b2b_done3");
    add(0, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 0, "b2b_gap_gnt");
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, "b2b_idle");
    // Grant to an idle channel.
    add(0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1, "idle_gnt_err");
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, "err_sticky");
    // Two grants at once; both requesting channels still count their beats.
    add(1, 4'b0011, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 0, "multi_push");
    add(0, 4'b0000, 4'b0011, 4'b0011, 4'b0000, 4'b0000, 1, "multi_gnt_err");
    add(0, 4'b0000, 4'b0001, 4'b0010, 4'b0001, 4'b0000, 1, "multi_done0");
    add(0, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1, "multi_done1");
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, "multi_idle");

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst_before) do_reset();
      step(tbl[i].push, tbl[i].gnt, tbl[i].req, tbl[i].done, tbl[i].full, tbl[i].err,
           tbl[i].name);
    end

    // Overflow on channel 0: 15 pushes fill it, the 16th is dropped and flagged.
    do_reset();
    for (int k = 1; k <= 15; k++)
      step(4'b0001, 4'b0000, 4'b0001, 4'b0000, (k == 15) ? 4'b0001 : 4'b0000, 1'b0,
           $sformatf("ovf_push%0d", k));
    step(4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 1'b1, "ovf_push16");
    step(4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, "ovf_beat1");
    step(4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b1, "ovf_drain");
    step(4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b1, "ovf_rereq");

    // Reset in the middle of a burst aborts it without a done pulse.
    do_reset();
    step(4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0, "mid_push");
    step(4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0, "mid_beat1");
    rst = 1'b0;
    #1;
    z = '{req: 4'd0, done: 4'd0, full: 4'd0, err: 1'b0, name: "mid_async_rst"};
    compare(z);
    gnt = 4'b0001;
    @(posedge clk);
    #1;
    gnt = 4'b0000;
    z.name = "mid_rst_held";
    compare(z);
    rst = 1'b1;
    step(4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0, "mid_repush");
    step(4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0, "mid_new_beat1");
    step(4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b0, "mid_new_done");
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, "mid_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
